// File: rtl/reg_file_ab.sv
// reg_file_ab: architectural register file for the multi-cycle CPU.
// One write port, two combinational read ports, a debug read port and
// the A/B operand latches that carry operands from decode to execute.
// Register 0 is hardwired to zero on every read path.

module reg_file_ab #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              ab_en,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] a_next;
    logic [DATA_W-1:0] b_next;
    logic              wr_valid;

    // A write only lands when enabled and not aimed at the zero register.
    assign wr_valid = we && (wa != '0);

    // Register array: cleared on reset, location 0 never written so it stays 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_valid) begin
            regs[wa] <= wd;
        end
    end

    // Plain array reads with no write-through; address 0 forced to zero.
    always_comb begin
        rd1      = (ra1 == '0)      ? '0 : regs[ra1];
        rd2      = (ra2 == '0)      ? '0 : regs[ra2];
        dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
    end

    // Operand values for the latches, bypassing a same-edge write.
    always_comb begin
        a_next = rd1;
        b_next = rd2;
        if (wr_valid && (wa == ra1)) begin
            a_next = wd;
        end
        if (wr_valid && (wa == ra2)) begin
            b_next = wd;
        end
    end

    // A/B operand latches load in decode and otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out <= '0;
            b_out <= '0;
        end else if (ab_en) begin
            a_out <= a_next;
            b_out <= b_next;
        end
    end

endmodule

// File: tb/tb_reg_file_ab.sv
// tb_reg_file_ab: directed plus randomized self-checking bench for
// reg_file_ab, compared against a simple array-based reference model.

module tb_reg_file_ab;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          ab_en;
    logic [DW-1:0] a_out;
    logic [DW-1:0] b_out;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;

    // Reference model state.
    logic [DW-1:0] mem [NR];
    logic [DW-1:0] mdl_a;
    logic [DW-1:0] mdl_b;

    int vectors;
    int miscompares;

    reg_file_ab #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .NREGS (NR)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra1     (ra1),
        .ra2     (ra2),
        .we      (we),
        .wa      (wa),
        .wd      (wd),
        .ab_en   (ab_en),
        .a_out   (a_out),
        .b_out   (b_out),
        .rd1     (rd1),
        .rd2     (rd2),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Value a register read yields: zero register reads 0, else stored value.
    function automatic logic [DW-1:0] readModel(input logic [AW-1:0] r);
        if (r == 0) return '0;
        return mem[r];
    endfunction

    // Value the latches should capture, including same-edge write-through.
    function automatic logic [DW-1:0] latchModel(input logic [AW-1:0] r);
        if (r == 0) return '0;
        if (we && wa == r) return wd;
        return mem[r];
    endfunction

    task automatic resetModel();
        for (int i = 0; i < NR; i++) mem[i] = '0;
        mdl_a = '0;
        mdl_b = '0;
    endtask

    task automatic checkOne(input string tag, input logic [DW-1:0] obs,
                            input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkOne({tag, "_rd1"},   rd1,      readModel(ra1));
        checkOne({tag, "_rd2"},   rd2,      readModel(ra2));
        checkOne({tag, "_dbg"},   dbg_data, readModel(dbg_addr));
        checkOne({tag, "_a_out"}, a_out,    mdl_a);
        checkOne({tag, "_b_out"}, b_out,    mdl_b);
    endtask

    // One clock edge with current inputs; model updated to match, sampled #1 after.
    task automatic step();
        logic [DW-1:0] va;
        logic [DW-1:0] vb;
        va = latchModel(ra1);
        vb = latchModel(ra2);
        @(posedge clk);
        #1;
        if (ab_en) begin
            mdl_a = va;
            mdl_b = vb;
        end
        if (we && wa != 0) mem[wa] = wd;
    endtask

    task automatic applyStimulus(input logic w, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input logic ab,
                                 input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        we    = w;
        wa    = a;
        wd    = d;
        ab_en = ab;
        ra1   = r1;
        ra2   = r2;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n    = 1'b0;
        dbg_addr = '0;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        resetModel();

        // Power-on reset state.
        #12;
        dbg_addr = 5'd17;
        #1;
        checkOutput("por");
        rst_n = 1'b1;

        // Write r5 and load latches, then reset asynchronously mid-cycle.
        applyStimulus(1'b1, 5'd5, 32'h12345678, 1'b1, 5'd5, 5'd5);
        step();
        checkOne("pre_rst_a", a_out, 32'h12345678);
        applyStimulus(1'b0, 5'd5, '0, 1'b0, 5'd5, 5'd5);
        #2;
        rst_n = 1'b0;
        #1;
        resetModel();
        checkOne("rst_rd1", rd1, 32'h0);
        checkOne("rst_a", a_out, 32'h0);
        checkOne("rst_b", b_out, 32'h0);

        // A write on an edge while reset is held must be discarded.
        applyStimulus(1'b1, 5'd9, 32'hA5A5A5A5, 1'b1, 5'd9, 5'd9);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b0, 5'd9, '0, 1'b0, 5'd9, 5'd9);
        dbg_addr = 5'd9;
        #1;
        checkOutput("rst_wr_discard");

        // Write / readback of r1 and r31, then latch them.
        applyStimulus(1'b1, 5'd1, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
        step();
        applyStimulus(1'b1, 5'd31, 32'h00000001, 1'b0, 5'd0, 5'd0);
        step();
        applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd1, 5'd31);
        #1;
        checkOne("wr_rd1", rd1, 32'hDEADBEEF);
        checkOne("wr_rd2", rd2, 32'h00000001);
        ab_en = 1'b1;
        step();
        ab_en = 1'b0;
        checkOne("wr_a", a_out, 32'hDEADBEEF);
        checkOne("wr_b", b_out, 32'h00000001);
        checkOutput("wr");

        // Zero register ignores writes and always reads 0.
        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0);
        dbg_addr = 5'd0;
        #1;
        checkOne("zero_rd1", rd1, 32'h0);
        checkOne("zero_dbg", dbg_data, 32'h0);
        step();
        checkOne("zero_a", a_out, 32'h0);
        checkOutput("zero");

        // Bypass: same-edge write to r7 is captured by both latches.
        applyStimulus(1'b1, 5'd7, 32'h11111111, 1'b0, 5'd0, 5'd0);
        step();
        applyStimulus(1'b1, 5'd7, 32'h22222222, 1'b1, 5'd7, 5'd7);
        #1;
        checkOne("byp_rd1_pre", rd1, 32'h11111111);
        step();
        checkOne("byp_a", a_out, 32'h22222222);
        checkOne("byp_b", b_out, 32'h22222222);
        checkOne("byp_rd1_post", rd1, 32'h22222222);
        checkOutput("byp");

        // Hold with ab_en low, then a disabled write must not land.
        applyStimulus(1'b1, 5'd3, 32'hCAFEF00D, 1'b0, 5'd3, 5'd7);
        step();
        checkOne("hold_a", a_out, 32'h22222222);
        applyStimulus(1'b0, 5'd3, 32'h0, 1'b0, 5'd3, 5'd7);
        dbg_addr = 5'd3;
        step();
        checkOne("wedis_dbg", dbg_data, 32'hCAFEF00D);
        checkOutput("hold");

        // Sweep every register through the debug port.
        for (int i = 1; i < NR; i++) begin
            applyStimulus(1'b1, AW'(i), DW'(i) * 32'h01010101, 1'b0, 5'd0, 5'd0);
            step();
        end
        we = 1'b0;
        for (int i = 0; i < NR; i++) begin
            dbg_addr = AW'(i);
            #1;
            checkOne("sweep_dbg", dbg_data, DW'(i) * 32'h01010101);
        end

        // Randomized traffic, biased to hit same-address bypass cases.
        for (int n = 0; n < 300; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), AW'($urandom), $urandom,
                          1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom));
            if ($urandom_range(0, 3) == 0) ra1 = wa;
            if ($urandom_range(0, 3) == 0) ra2 = wa;
            dbg_addr = AW'($urandom);
            #1;
            checkOutput("rand_pre");
            step();
            checkOutput("rand_post");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_file_ab.md
Name: reg_file_ab

Overview:
- Architectural register file for the multi-cycle CPU.
- Sits directly downstream of the 5-bit destination-register select mux (rt/rd choice):
  - `wa` is driven by that mux's output.
  - `ra1`/`ra2` come from the instruction register's rs/rt fields.
- Provides one write port and two read ports.
- Includes the A/B operand latches the multi-cycle datapath needs between decode and execute.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width.
- NREGS, 32, number of registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ra1  input  ADDR_W  read address 1 (rs).
- ra2  input  ADDR_W  read address 2 (rt).
- we  input  1  register write enable (RegWrite from control FSM).
- wa  input  ADDR_W  write address (from destination-select mux).
- wd  input  DATA_W  write data (ALUOut or MDR, selected upstream).
- ab_en  input  1  load A/B latches this cycle (asserted in decode state).
- a_out  output  DATA_W  registered operand A.
- b_out  output  DATA_W  registered operand B.
- rd1  output  DATA_W  combinational read of ra1, no bypass.
- rd2  output  DATA_W  combinational read of ra2, no bypass.
- dbg_addr  input  ADDR_W  debug/display read address.
- dbg_data  output  DATA_W  combinational read of dbg_addr, no bypass.

Behaviour:
- Interface: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset (`rst_n`=0, asynchronous, any time including mid-write):
  - All NREGS registers, `a_out` and `b_out` clear to 0 immediately.
  - `rd1`/`rd2`/`dbg_data` therefore read 0.
  - A write on a clock edge coincident with reset asserted is discarded.
- Release:
  - Deassertion is assumed synchronised externally.
  - The first rising edge with `rst_n`=1 may write.
- Register 0:
  - Hardwired zero. Writes with `wa`=0 are ignored.
  - Every read of address 0 (rd1, rd2, a_out load, dbg) returns 0.
  - Storage for reg 0 may be omitted.
- Write:
  - On rising edge, if `we`=1 and `wa`!=0, regs[wa] <= wd.
  - Visible on rd1/rd2/dbg_data after the edge; 1-cycle write latency.
- Combinational reads:
  - rd1 = regs[ra1], rd2 = regs[ra2], dbg_data = regs[dbg_addr].
  - Pure array reads; no write-through.
- A/B latches:
  - On rising edge, if `ab_en`=1:
    - a_out <= value(ra1)
    - b_out <= value(ra2)
  - value(r) = 0 if r=0; else wd if (we=1 and wa=r); else regs[r]. This is write-through bypass, so a same-edge write is not lost.
  - If `ab_en`=0, a_out/b_out hold.
  - Latency: 1 edge from `ab_en` to new a_out/b_out.
- Simultaneous events:
  - ra1=ra2=wa with we=1 and ab_en=1: both latches load wd and the array updates; all on the same edge.
  - we=1, wa=0, ab_en=1, ra1=0: a_out loads 0, not wd.
- Out-of-range addresses: not possible, since NREGS=2**ADDR_W.
- No X propagation from the array after reset: every location is defined.

Test Plan:
- Reset: write 0x12345678 to r5, then pulse `rst_n` low mid-cycle (asynchronously) → rd1 (ra1=5), a_out, b_out all read 0 before the next edge.
- Write/readback:
  - Write r1=0xDEADBEEF and r31=0x00000001 on successive edges.
  - Then set ra1=1, ra2=31 → rd1=0xDEADBEEF, rd2=0x00000001.
  - Pulse ab_en → a_out/b_out equal the same values one edge later.
- Zero register: we=1, wa=0, wd=0xFFFFFFFF → rd1 (ra1=0)=0, dbg_data (dbg_addr=0)=0, and a_out loads 0 on ab_en.
- Bypass:
  - r7=0x11111111.
  - Same edge: we=1, wa=7, wd=0x22222222, ab_en=1, ra1=ra2=7 → a_out=b_out=0x22222222.
  - rd1 before the edge = 0x11111111, after = 0x22222222.
- Hold / write-disable:
  - ab_en=0 while r3 is rewritten to 0xCAFEF00D → a_out unchanged.
  - we=0 with wa=3, wd=0 → r3 stays 0xCAFEF00D.
- Sweep: write regs[i]=i*0x01010101 for i=1..31, then read all via dbg_addr → exact match; dbg_addr=0 reads 0.
